// File: rtl/ex_mem_wb_arbiter.sv
// ex_mem_wb_arbiter
// Collects completed results from FU0 (ALU), FU1 (ALU/MUL) and FU2 (LSU) into
// private DEPTH-entry FIFOs. A round-robin scheduler places up to two queue
// heads per cycle onto the two registered result-broadcast ports.
// Optional feature macro: ARB_PERF_CNT_EN adds backpressure and dual-issue
// performance counters (perf_bp0/1/2, perf_dual).
module ex_mem_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              out_stall,
    input  logic [2:0]        fu_valid,
    output logic [2:0]        fu_ready,
    input  logic [DATA_W-1:0] fu0_result,
    input  logic [DATA_W-1:0] fu1_result,
    input  logic [DATA_W-1:0] fu2_result,
    input  logic [DATA_W-1:0] fu0_pc,
    input  logic [DATA_W-1:0] fu1_pc,
    input  logic [DATA_W-1:0] fu2_pc,
    input  logic [TAG_W-1:0]  fu0_tag,
    input  logic [TAG_W-1:0]  fu1_tag,
    input  logic [TAG_W-1:0]  fu2_tag,
    output logic              p0_valid,
    output logic              p1_valid,
    output logic [DATA_W-1:0] p0_result,
    output logic [DATA_W-1:0] p1_result,
    output logic [DATA_W-1:0] p0_pc,
    output logic [DATA_W-1:0] p1_pc,
    output logic [TAG_W-1:0]  p0_tag,
    output logic [TAG_W-1:0]  p1_tag,
    output logic [1:0]        p0_src,
    output logic [1:0]        p1_src,
    output logic [2:0]        tunnel_out
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bp0,
    output logic [31:0]       perf_bp1,
    output logic [31:0]       perf_bp2,
    output logic [31:0]       perf_dual
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 2 * DATA_W + TAG_W;

    // Entry layout: {result, pc, tag}
    logic [EW-1:0] fu_entry [3];
    logic [EW-1:0] mem      [3][DEPTH];
    logic [PW-1:0] wr_ptr   [3];
    logic [PW-1:0] rd_ptr   [3];
    logic [CW-1:0] cnt      [3];
    logic [EW-1:0] head     [3];

    logic [2:0]    enq;
    logic [2:0]    deq;
    logic [2:0]    non_empty;

    logic [1:0]    rr_ptr;
    logic          gnt0_vld;
    logic          gnt1_vld;
    logic [1:0]    gnt0_idx;
    logic [1:0]    gnt1_idx;
    logic [2:0]    scan_sum;
    logic [1:0]    scan_idx;
    logic [EW-1:0] gnt0_entry;
    logic [EW-1:0] gnt1_entry;

    // Pack FU inputs and derive per-queue status from registered counts only
    always_comb begin
        fu_entry[0] = {fu0_result, fu0_pc, fu0_tag};
        fu_entry[1] = {fu1_result, fu1_pc, fu1_tag};
        fu_entry[2] = {fu2_result, fu2_pc, fu2_tag};
        for (int i = 0; i < 3; i++) begin
            fu_ready[i]  = (cnt[i] < CW'(DEPTH));
            non_empty[i] = (cnt[i] != '0);
            enq[i]       = fu_valid[i] & fu_ready[i] & ~flush;
            head[i]      = mem[i][rd_ptr[i]];
        end
    end

    // Round-robin scan from rr_ptr: first non-empty head to port 0, second to port 1
    always_comb begin
        gnt0_vld = 1'b0;
        gnt1_vld = 1'b0;
        gnt0_idx = 2'd0;
        gnt1_idx = 2'd0;
        scan_sum = 3'd0;
        scan_idx = 2'd0;
        if (!flush && !out_stall) begin
            for (int k = 0; k < 3; k++) begin
                scan_sum = {1'b0, rr_ptr} + 3'(k);
                if (scan_sum >= 3'd3) begin
                    scan_sum = scan_sum - 3'd3;
                end
                scan_idx = scan_sum[1:0];
                if (non_empty[scan_idx]) begin
                    if (!gnt0_vld) begin
                        gnt0_vld = 1'b1;
                        gnt0_idx = scan_idx;
                    end else if (!gnt1_vld) begin
                        gnt1_vld = 1'b1;
                        gnt1_idx = scan_idx;
                    end
                end
            end
        end
    end

    // Dequeue strobes and payload selection for the two grants
    always_comb begin
        deq = 3'b000;
        if (gnt0_vld) deq[gnt0_idx] = 1'b1;
        if (gnt1_vld) deq[gnt1_idx] = 1'b1;
        gnt0_entry = head[gnt0_idx];
        gnt1_entry = head[gnt1_idx];
    end

    // Queue storage; contents need no reset because counts gate visibility
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (enq[i]) begin
                mem[i][wr_ptr[i]] <= fu_entry[i];
            end
        end
    end

    // Queue pointers and occupancy; flush and reset both empty every queue
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn || flush) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end else begin
                if (enq[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (deq[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (enq[i] && !deq[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!enq[i] && deq[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    // Round-robin pointer moves past the last granted FU; idle cycles hold it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr <= 2'd0;
        end else if (gnt1_vld) begin
            rr_ptr <= (gnt1_idx == 2'd2) ? 2'd0 : gnt1_idx + 2'd1;
        end else if (gnt0_vld) begin
            rr_ptr <= (gnt0_idx == 2'd2) ? 2'd0 : gnt0_idx + 2'd1;
        end
    end

    // Broadcast port registers; an ungranted port drops valid and keeps its payload
    always_ff @(posedge clk) begin
        if (!rstn) begin
            p0_valid   <= 1'b0;
            p1_valid   <= 1'b0;
            p0_result  <= '0;
            p1_result  <= '0;
            p0_pc      <= '0;
            p1_pc      <= '0;
            p0_tag     <= '0;
            p1_tag     <= '0;
            p0_src     <= 2'd0;
            p1_src     <= 2'd0;
            tunnel_out <= 3'b000;
        end else begin
            p0_valid   <= gnt0_vld;
            p1_valid   <= gnt1_vld;
            tunnel_out <= deq;
            if (gnt0_vld) begin
                {p0_result, p0_pc, p0_tag} <= gnt0_entry;
                p0_src <= gnt0_idx;
            end
            if (gnt1_vld) begin
                {p1_result, p1_pc, p1_tag} <= gnt1_entry;
                p1_src <= gnt1_idx;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_bp [3];

    assign perf_bp0 = perf_bp[0];
    assign perf_bp1 = perf_bp[1];
    assign perf_bp2 = perf_bp[2];

    // Saturating counters; only rstn clears them so they survive mispredict flushes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) perf_bp[i] <= '0;
            perf_dual <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fu_valid[i] && !fu_ready[i] && perf_bp[i] != 32'hFFFF_FFFF) begin
                    perf_bp[i] <= perf_bp[i] + 32'd1;
                end
            end
            if (gnt1_vld && perf_dual != 32'hFFFF_FFFF) begin
                perf_dual <= perf_dual + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_wb_arbiter.sv
// Self-checking bench for ex_mem_wb_arbiter (default build, DEPTH=2).
// A queue-based reference model predicts ready, port and tunnel values each edge.
module tb_ex_mem_wb_arbiter;

    localparam int DEPTH  = 2;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int EW     = 2 * DATA_W + TAG_W;

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush;
    logic              out_stall;
    logic [2:0]        fu_valid;
    logic [2:0]        fu_ready;
    logic [DATA_W-1:0] res [3];
    logic [DATA_W-1:0] pc  [3];
    logic [TAG_W-1:0]  tag [3];
    logic              p0_valid, p1_valid;
    logic [DATA_W-1:0] p0_result, p1_result, p0_pc, p1_pc;
    logic [TAG_W-1:0]  p0_tag, p1_tag;
    logic [1:0]        p0_src, p1_src;
    logic [2:0]        tunnel_out;

    always #5 clk = ~clk;

    ex_mem_wb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .out_stall  (out_stall),
        .fu_valid   (fu_valid),
        .fu_ready   (fu_ready),
        .fu0_result (res[0]),
        .fu1_result (res[1]),
        .fu2_result (res[2]),
        .fu0_pc     (pc[0]),
        .fu1_pc     (pc[1]),
        .fu2_pc     (pc[2]),
        .fu0_tag    (tag[0]),
        .fu1_tag    (tag[1]),
        .fu2_tag    (tag[2]),
        .p0_valid   (p0_valid),
        .p1_valid   (p1_valid),
        .p0_result  (p0_result),
        .p1_result  (p1_result),
        .p0_pc      (p0_pc),
        .p1_pc      (p1_pc),
        .p0_tag     (p0_tag),
        .p1_tag     (p1_tag),
        .p0_src     (p0_src),
        .p1_src     (p1_src),
        .tunnel_out (tunnel_out)
    );

    // Reference model state
    logic [EW-1:0]     mq [3][$];
    int                rr;
    logic              e_vld [2];
    logic [DATA_W-1:0] e_res [2];
    logic [DATA_W-1:0] e_pc  [2];
    logic [TAG_W-1:0]  e_tag [2];
    logic [1:0]        e_src [2];
    logic [2:0]        e_tun;

    int n_vec = 0;
    int n_err = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    task automatic model_edge();
        logic [2:0]    rdy;
        logic [EW-1:0] ent;
        int            picked [2];
        int            n;
        int            idx;
        rdy = model_ready();
        if (!rstn) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            rr = 0;
            for (int p = 0; p < 2; p++) begin
                e_vld[p] = 0; e_res[p] = 0; e_pc[p] = 0; e_tag[p] = 0; e_src[p] = 0;
            end
            e_tun = 0;
        end else if (flush) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            e_vld[0] = 0; e_vld[1] = 0; e_tun = 0;
        end else begin
            n = 0;
            picked[0] = 0; picked[1] = 0;
            if (!out_stall) begin
                for (int k = 0; k < 3; k++) begin
                    idx = (rr + k) % 3;
                    if (mq[idx].size() > 0 && n < 2) begin
                        picked[n] = idx;
                        n++;
                    end
                end
            end
            e_tun = 0;
            for (int p = 0; p < 2; p++) begin
                if (p < n) begin
                    ent = mq[picked[p]].pop_front();
                    e_vld[p] = 1;
                    {e_res[p], e_pc[p], e_tag[p]} = ent;
                    e_src[p] = 2'(picked[p]);
                    e_tun[picked[p]] = 1'b1;
                end else begin
                    e_vld[p] = 0;
                end
            end
            if (n > 0) rr = (picked[n-1] + 1) % 3;
            for (int i = 0; i < 3; i++) begin
                if (fu_valid[i] && rdy[i]) mq[i].push_back({res[i], pc[i], tag[i]});
            end
        end
    endtask

    task automatic tick();
        if (started) chk("fu_ready", 64'(fu_ready), 64'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("p0_valid",  64'(p0_valid),  64'(e_vld[0]));
        chk("p1_valid",  64'(p1_valid),  64'(e_vld[1]));
        chk("p0_result", 64'(p0_result), 64'(e_res[0]));
        chk("p1_result", 64'(p1_result), 64'(e_res[1]));
        chk("p0_pc",     64'(p0_pc),     64'(e_pc[0]));
        chk("p1_pc",     64'(p1_pc),     64'(e_pc[1]));
        chk("p0_tag",    64'(p0_tag),    64'(e_tag[0]));
        chk("p1_tag",    64'(p1_tag),    64'(e_tag[1]));
        chk("p0_src",    64'(p0_src),    64'(e_src[0]));
        chk("p1_src",    64'(p1_src),    64'(e_src[1]));
        chk("tunnel",    64'(tunnel_out), 64'(e_tun));
        @(negedge clk);
    endtask

    task automatic set_fu(input int i, input logic [31:0] r, input logic [31:0] p, input logic [5:0] t);
        res[i] = r; pc[i] = p; tag[i] = t;
    endtask

    task automatic do_reset();
        rstn = 1'b0; fu_valid = 3'b000; flush = 1'b0; out_stall = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; out_stall = 1'b0; fu_valid = 3'b000;
        for (int i = 0; i < 3; i++) set_fu(i, 32'h0, 32'h0, 6'h0);
        tick();
        tick();
        started = 1;
        chk("rst_ready", 64'(fu_ready), 64'h7);
        rstn = 1'b1;

        // Single FU0 result, two-edge latency
        set_fu(0, 32'h1234, 32'h100, 6'd5);
        fu_valid = 3'b001;
        tick();
        chk("lat_p0_early", 64'(p0_valid), 64'h0);
        fu_valid = 3'b000;
        tick();
        chk("t1_p0_valid", 64'(p0_valid), 64'h1);
        chk("t1_p0_src", 64'(p0_src), 64'h0);
        chk("t1_p0_result", 64'(p0_result), 64'h1234);
        chk("t1_p1_valid", 64'(p1_valid), 64'h0);
        chk("t1_tunnel", 64'(tunnel_out), 64'h1);

        // All three FUs at once from rr_ptr=0
        do_reset();
        set_fu(0, 32'hA0, 32'h200, 6'd1);
        set_fu(1, 32'hA1, 32'h204, 6'd2);
        set_fu(2, 32'hA2, 32'h208, 6'd3);
        fu_valid = 3'b111;
        tick();
        fu_valid = 3'b000;
        tick();
        chk("t2_p0_src", 64'(p0_src), 64'h0);
        chk("t2_p1_src", 64'(p1_src), 64'h1);
        chk("t2_tunnel", 64'(tunnel_out), 64'h3);
        tick();
        chk("t2b_p0_src", 64'(p0_src), 64'h2);
        chk("t2b_tunnel", 64'(tunnel_out), 64'h4);
        chk("t2b_p1_valid", 64'(p1_valid), 64'h0);

        // FU2 backpressure under stall, then in-order drain
        out_stall = 1'b1;
        fu_valid = 3'b100;
        for (int c = 0; c < 4; c++) begin
            set_fu(2, 32'hB00 + 32'(c), 32'h300 + 32'(4 * c), 6'(10 + c));
            tick();
            chk("st_p0_valid", 64'(p0_valid), 64'h0);
        end
        chk("st_ready2", 64'(fu_ready[2]), 64'h0);
        out_stall = 1'b0;
        fu_valid = 3'b000;
        tick();
        chk("dr0_tag", 64'(p0_tag), 64'd10);
        chk("dr0_src", 64'(p0_src), 64'h2);
        tick();
        chk("dr1_tag", 64'(p0_tag), 64'd11);
        tick();
        chk("dr2_valid", 64'(p0_valid), 64'h0);

        // Flush with queued FU0/FU1 entries and simultaneous inputs
        out_stall = 1'b1;
        fu_valid = 3'b011;
        set_fu(0, 32'hC0, 32'h400, 6'd20);
        set_fu(1, 32'hC1, 32'h404, 6'd21);
        tick();
        tick();
        flush = 1'b1;
        fu_valid = 3'b111;
        tick();
        chk("fl_p0_valid", 64'(p0_valid), 64'h0);
        chk("fl_p1_valid", 64'(p1_valid), 64'h0);
        chk("fl_tunnel", 64'(tunnel_out), 64'h0);
        chk("fl_ready", 64'(fu_ready), 64'h7);
        flush = 1'b0;
        out_stall = 1'b0;
        fu_valid = 3'b000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fl_empty", 64'(p0_valid), 64'h0);
        end

        // Continuous traffic from all FUs
        fu_valid = 3'b111;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 3; i++) set_fu(i, $urandom, $urandom, 6'($urandom));
            tick();
        end

        // Randomized traffic with stalls, flushes and occasional reset
        for (int c = 0; c < 3000; c++) begin
            rstn      = ($urandom_range(0, 249) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            out_stall = ($urandom_range(0, 5) == 0);
            fu_valid  = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) set_fu(i, $urandom, $urandom, 6'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
